mem_bram_responder: RTL and testbench

// - Responder (slave) end of the mem_req/mem_resp tagged memory bus that the soft-CPU subsystem drives as initiator.
// - Serves requests from a local 32-bit block RAM: byte-enabled writes, and pipelined reads with a fixed latency.
// - Stalls periodically to model refresh-style back-pressure, so requester hold/retry logic runs on-chip without the SDRAM controller.

---
 rtl/mem_bram_responder_if.sv | 25 ++
 rtl/mem_bram_responder.sv | 99 +++++++++
 tb/tb_mem_bram_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bram_responder_if.sv
// Tagged memory bus between the soft-CPU initiator and a memory responder.
// Request fields are driven by the initiator; rack/dack/data by the responder.
interface mem_bram_responder_if;
    logic        mem_req_request;
    logic [7:0]  mem_req_tag;
    logic [25:0] mem_req_address;
    logic        mem_req_read_writen;
    logic [3:0]  mem_req_byte_en;
    logic [31:0] mem_req_wdata;
    logic [7:0]  mem_resp_rack_tag;
    logic [7:0]  mem_resp_dack_tag;
    logic [31:0] mem_resp_data;

    modport master (
        output mem_req_request, mem_req_tag, mem_req_address,
               mem_req_read_writen, mem_req_byte_en, mem_req_wdata,
        input  mem_resp_rack_tag, mem_resp_dack_tag, mem_resp_data
    );

    modport slave (
        input  mem_req_request, mem_req_tag, mem_req_address,
               mem_req_read_writen, mem_req_byte_en, mem_req_wdata,
        output mem_resp_rack_tag, mem_resp_dack_tag, mem_resp_data
    );
endinterface

// File: rtl/mem_bram_responder.sv
// Block-RAM responder for the tagged memory bus: byte-enabled writes,
// fixed-latency pipelined reads, and optional periodic back-pressure.
//
// state | meaning
// RUN   | requests are accepted
// STALL | requests refused (refresh-style window), reads in flight continue
module mem_bram_responder #(
    parameter int ADDR_BITS    = 12,
    parameter int READ_LATENCY = 2,
    parameter int STALL_PERIOD = 0,
    parameter int STALL_LEN    = 2
) (
    input logic            clock,
    input logic            reset,
    mem_bram_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int CW    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    logic [31:0]          ram [DEPTH];
    logic [ADDR_BITS-1:0] word;
    logic                 stall;
    logic                 accept;
    logic                 rd_accept;
    logic                 wr_accept;
    logic [7:0]           rd_tag;
    logic                 unused_addr;

    logic [7:0]  tag_pipe  [READ_LATENCY];
    logic [31:0] data_pipe [READ_LATENCY];

    // Upper address bits alias and the byte offset is irrelevant for word access.
    assign word        = bus.mem_req_address[ADDR_BITS+1:2];
    assign unused_addr = ^bus.mem_req_address;

    // Reset is folded into accept so a write on a reset edge is dropped.
    assign accept    = bus.mem_req_request & ~stall & ~reset;
    assign rd_accept = accept & bus.mem_req_read_writen;
    assign wr_accept = accept & ~bus.mem_req_read_writen;
    assign rd_tag    = rd_accept ? bus.mem_req_tag : 8'h00;

    assign bus.mem_resp_rack_tag = accept ? bus.mem_req_tag : 8'h00;
    assign bus.mem_resp_dack_tag = tag_pipe[READ_LATENCY-1];
    assign bus.mem_resp_data     = data_pipe[READ_LATENCY-1];

    generate
        if (STALL_PERIOD > 0) begin : g_stall
            typedef enum logic {RUN, STALL} state_t;
            state_t        state;
            logic [CW-1:0] count;

            // Free-running period counter and RUN/STALL window sequencing.
            always_ff @(posedge clock) begin
                if (reset) begin
                    state <= RUN;
                    count <= '0;
                end else begin
                    count <= (count == CW'(STALL_PERIOD - 1)) ? '0 : count + CW'(1);
                    case (state)
                        RUN:     if (count == CW'(STALL_PERIOD - STALL_LEN - 1)) state <= STALL;
                        STALL:   if (count == CW'(STALL_PERIOD - 1)) state <= RUN;
                        default: state <= RUN;
                    endcase
                end
            end

            assign stall = (state == STALL);
        end else begin : g_no_stall
            assign stall = 1'b0;
        end
    endgenerate

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_req_byte_en[i]) ram[word][8*i +: 8] <= bus.mem_req_wdata[8*i +: 8];
            end
        end
    end

    // Read pipeline: data captured at accept, data stages only load on valid
    // entries so the output holds its last value between dacks.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_pipe[i]  <= 8'h00;
                data_pipe[i] <= 32'h0;
            end
        end else begin
            tag_pipe[0] <= rd_tag;
            if (rd_accept) data_pipe[0] <= ram[word];
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
                if (tag_pipe[i-1] != 8'h00) data_pipe[i] <= data_pipe[i-1];
            end
        end
    end
endmodule

// File: tb/tb_mem_bram_responder.sv
// Self-checking bench for mem_bram_responder: directed scenarios followed by
// randomized traffic, compared against a cycle-indexed behavioural model.
module tb_mem_bram_responder;
    localparam int ADDR_BITS    = 12;
    localparam int LAT          = 3;
    localparam int STALL_PERIOD = 8;
    localparam int STALL_LEN    = 2;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;

    logic [31:0] ram_m   [int];
    logic [7:0]  exp_tag [int];
    logic [31:0] exp_dat [int];
    logic [31:0] last_data;

    mem_bram_responder_if bus ();

    mem_bram_responder #(
        .ADDR_BITS(ADDR_BITS), .READ_LATENCY(LAT),
        .STALL_PERIOD(STALL_PERIOD), .STALL_LEN(STALL_LEN)
    ) dut (
        .clock(clk),
        .reset(reset),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    // One bus cycle: drive, check outputs mid-cycle, then advance the model.
    task automatic step(input bit req, input logic [7:0] tg, input logic [25:0] ad,
                        input bit rd, input logic [3:0] be, input logic [31:0] wd,
                        output bit acc);
        bit          stall_now;
        logic [7:0]  e_rack;
        logic [7:0]  e_dack;
        logic [31:0] e_data;
        int          w;
        bus.mem_req_request     = req;
        bus.mem_req_tag         = tg;
        bus.mem_req_address     = ad;
        bus.mem_req_read_writen = rd;
        bus.mem_req_byte_en     = be;
        bus.mem_req_wdata       = wd;
        stall_now = (cyc % STALL_PERIOD) >= (STALL_PERIOD - STALL_LEN);
        acc       = req && !stall_now;
        e_rack    = acc ? tg : 8'h00;
        if (exp_tag.exists(cyc)) begin
            e_dack    = exp_tag[cyc];
            e_data    = exp_dat[cyc];
            last_data = e_data;
        end else begin
            e_dack = 8'h00;
            e_data = last_data;
        end
        @(negedge clk);
        check("rack_tag", 32'(bus.mem_resp_rack_tag), 32'(e_rack));
        check("dack_tag", 32'(bus.mem_resp_dack_tag), 32'(e_dack));
        check("data", bus.mem_resp_data, e_data);
        @(posedge clk);
        w = int'(ad >> 2) % (1 << ADDR_BITS);
        if (acc) begin
            if (rd) begin
                exp_tag[cyc + LAT] = tg;
                exp_dat[cyc + LAT] = ram_m[w];
            end else begin
                if (!ram_m.exists(w)) ram_m[w] = 'x;
                for (int i = 0; i < 4; i++)
                    if (be[i]) ram_m[w][8*i +: 8] = wd[8*i +: 8];
            end
        end
        cyc++;
        #1;
    endtask

    // Hold a request until the model says it is accepted (bounded).
    task automatic issue(input logic [7:0] tg, input logic [25:0] ad, input bit rd,
                         input logic [3:0] be, input logic [31:0] wd);
        bit acc;
        int n;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            step(1'b1, tg, ad, rd, be, wd, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $error("FAIL issue_timeout observed=no_accept expected=accept tag=%h", tg);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(1'b0, 8'h00, 26'h0, 1'b0, 4'h0, 32'h0, acc);
    endtask

    // Reset with a write request held; the write must never land.
    task automatic do_reset(input int n, input logic [25:0] ad, input logic [31:0] wd);
        reset                   = 1'b1;
        bus.mem_req_request     = 1'b1;
        bus.mem_req_tag         = 8'h77;
        bus.mem_req_address     = ad;
        bus.mem_req_read_writen = 1'b0;
        bus.mem_req_byte_en     = 4'hF;
        bus.mem_req_wdata       = wd;
        repeat (n) begin
            @(negedge clk);
            check("rack_in_reset", 32'(bus.mem_resp_rack_tag), 32'h0);
            @(posedge clk);
            #1;
        end
        reset               = 1'b0;
        bus.mem_req_request = 1'b0;
        cyc                 = 0;
        last_data           = 32'h0;
        exp_tag.delete();
        exp_dat.delete();
    endtask

    initial begin
        bit          have;
        bit          acc;
        logic [7:0]  r_tag;
        logic [25:0] r_addr;
        logic        r_rd;
        logic [3:0]  r_be;
        logic [31:0] r_wd;
        logic [11:0] up;
        logic [11:0] wi;
        logic [1:0]  lo;

        checks    = 0;
        failures  = 0;
        cyc       = 0;
        last_data = 32'h0;

        // Power-up reset then quiet bus.
        do_reset(3, 26'h0, 32'hFFFF_FFFF);
        idle(10);

        // Write then read the same word.
        issue(8'h11, 26'h40, 1'b0, 4'hF, 32'hDEAD_BEEF);
        issue(8'h12, 26'h40, 1'b1, 4'h0, 32'h0);
        idle(LAT + 2);

        // Partial-lane write over a cleared word.
        issue(8'h21, 26'h80, 1'b0, 4'hF, 32'h0000_0000);
        issue(8'h22, 26'h80, 1'b0, 4'b0101, 32'hAABB_CCDD);
        issue(8'h23, 26'h80, 1'b1, 4'h0, 32'h0);
        idle(LAT + 2);

        // Byte-enable of zero is accepted but writes nothing.
        issue(8'h24, 26'h80, 1'b0, 4'h0, 32'h1234_5678);
        issue(8'h25, 26'h80, 1'b1, 4'h0, 32'h0);
        idle(LAT + 2);

        // Four back-to-back reads aligned to the start of a RUN window.
        while (cyc % STALL_PERIOD != 0) idle(1);
        for (int t = 1; t <= 4; t++) issue(8'(t), 26'h40, 1'b1, 4'h0, 32'h0);
        idle(LAT + 2);

        // Address aliasing above ADDR_BITS+1.
        issue(8'h31, 26'h0000, 1'b0, 4'hF, 32'h5A5A_5A5A);
        issue(8'h32, 26'h4000, 1'b1, 4'h0, 32'h0);
        idle(LAT + 2);

        // Prewrite a small working set for later reads.
        for (int w = 0; w < 16; w++) issue(8'(8'h40 + w), 26'(w * 4), 1'b0, 4'hF, $urandom);

        // Request held continuously across stall windows.
        for (int t = 0; t < 12; t++) issue(8'(8'h60 + t), 26'((t % 16) * 4), 1'b1, 4'h0, 32'h0);
        idle(LAT + 2);

        // Reset one cycle after a read: no dack, RAM contents retained.
        issue(8'h71, 26'h40, 1'b1, 4'h0, 32'h0);
        do_reset(2, 26'h40, 32'h1234_5678);
        idle(LAT + 3);
        issue(8'h72, 26'h40, 1'b1, 4'h0, 32'h0);
        idle(LAT + 2);

        // Randomized traffic over the prewritten words with aliased addresses.
        have   = 1'b0;
        r_tag  = 8'h0;
        r_addr = 26'h0;
        r_rd   = 1'b0;
        r_be   = 4'h0;
        r_wd   = 32'h0;
        for (int n = 0; n < 400; n++) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                up     = 12'($urandom_range(0, 4095));
                wi     = 12'($urandom_range(0, 15));
                lo     = 2'($urandom_range(0, 3));
                r_addr = {up, wi, lo};
                r_tag  = 8'($urandom_range(1, 255));
                r_rd   = 1'($urandom_range(0, 1));
                r_be   = 4'($urandom_range(0, 15));
                r_wd   = $urandom;
                have   = 1'b1;
            end
            step(have, r_tag, r_addr, r_rd, r_be, r_wd, acc);
            if (acc) have = 1'b0;
        end
        idle(LAT + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
